// File: rtl/kd_tree_ctrl.sv
// ============================================================================
// Module  : kd_tree_ctrl
// Brief   : Load/search sequencer for internal_node_tree: gates node beats in,
//           then issues query patches and returns leaf indices in order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module kd_tree_ctrl #(
  parameter int PATCH_WIDTH   = 55,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_NODES     = 63,
  parameter int TREE_LATENCY  = 2,
  parameter int PIPELINED     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     node_enq,
  output logic                     node_full_n,
  output logic                     fsm_enable,
  output logic                     load_done,
  input  logic                     patch_valid,
  output logic                     patch_ready,
  input  logic [PATCH_WIDTH-1:0]   patch_data,
  output logic [PATCH_WIDTH-1:0]   tree_patch,
  input  logic [ADDRESS_WIDTH-1:0] tree_leaf_idx,
  output logic                     result_valid,
  output logic [ADDRESS_WIDTH-1:0] result_index,
  output logic                     busy,
  output logic                     proto_err
);

  localparam int CNT_W = $clog2(NUM_NODES + 1);
  localparam logic [CNT_W-1:0] LAST_NODE = CNT_W'(NUM_NODES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEARCH = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  // Bits [TREE_LATENCY-1:0] track the tree pipeline; the top bit marks a patch
  // whose leaf index has been stable for a full cycle and is captured next edge.
  logic [TREE_LATENCY:0]    vsr_q, vsr_d;
  logic                     reload_pend_q, reload_pend_d;
  logic                     load_done_q, load_done_d;
  logic                     result_valid_q, result_valid_d;
  logic                     proto_err_q, proto_err_d;
  logic [ADDRESS_WIDTH-1:0] result_index_q, result_index_d;
  logic [PATCH_WIDTH-1:0]   tree_patch_q, tree_patch_d;
  logic                     accept;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    reload_pend_d  = reload_pend_q;
    load_done_d    = 1'b0;
    proto_err_d    = proto_err_q;
    result_index_d = result_index_q;
    tree_patch_d   = tree_patch_q;

    node_full_n = (state_q == LOAD);
    fsm_enable  = (state_q == LOAD);
    busy        = (state_q != IDLE);
    patch_ready = (state_q == SEARCH) && !reload_pend_q &&
                  ((PIPELINED != 0) || (vsr_q[TREE_LATENCY-1:0] == '0));
    accept      = patch_valid && patch_ready;

    vsr_d          = {vsr_q[TREE_LATENCY-1:0], accept};
    result_valid_d = vsr_q[TREE_LATENCY];
    if (vsr_q[TREE_LATENCY]) begin
      result_index_d = tree_leaf_idx;
    end
    if (accept) begin
      tree_patch_d = patch_data;
    end
    if (node_enq && (state_q != LOAD)) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // A restart takes priority over the final beat.
        if (start) begin
          cnt_d = '0;
        end else if (node_enq) begin
          if (cnt_q == LAST_NODE) begin
            cnt_d       = '0;
            load_done_d = 1'b1;
            state_d     = SEARCH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SEARCH: begin
        if (reload_pend_q && (vsr_q == '0)) begin
          state_d       = LOAD;
          cnt_d         = '0;
          reload_pend_d = 1'b0;
        end else if (start) begin
          reload_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      vsr_q          <= '0;
      reload_pend_q  <= 1'b0;
      load_done_q    <= 1'b0;
      result_valid_q <= 1'b0;
      proto_err_q    <= 1'b0;
      result_index_q <= '0;
      tree_patch_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      vsr_q          <= vsr_d;
      reload_pend_q  <= reload_pend_d;
      load_done_q    <= load_done_d;
      result_valid_q <= result_valid_d;
      proto_err_q    <= proto_err_d;
      result_index_q <= result_index_d;
      tree_patch_q   <= tree_patch_d;
    end
  end

  assign load_done    = load_done_q;
  assign result_valid = result_valid_q;
  assign result_index = result_index_q;
  assign tree_patch   = tree_patch_q;
  assign proto_err    = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_kd_tree_ctrl.sv
// ============================================================================
// Module  : tb_kd_tree_ctrl
// Brief   : Self-checking bench for kd_tree_ctrl; a pipelined and a
//           one-outstanding instance run side by side against a queue model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kd_tree_ctrl;

  localparam int PW = 55;
  localparam int AW = 8;
  localparam int NN = 63;
  localparam int TL = 2;

  typedef struct {
    logic [PW-1:0] p;
    int            a;
  } item_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          node_enq = 1'b0;
  logic          patch_valid = 1'b0;
  logic [PW-1:0] patch_data = '0;

  int checks = 0;
  int errors = 0;
  int ld_count = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pat(input int leaf);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return {r[PW-1:AW], leaf[AW-1:0]};
  endfunction

  // g_inst[0]: PIPELINED=1, g_inst[1]: PIPELINED=0
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int P = (g == 0) ? 1 : 0;

    logic          w_nfn, w_fe, w_ld, w_pr, w_rv, w_busy, w_perr;
    logic [PW-1:0] w_tp;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] h1 = '0;
    logic [AW-1:0] leaf = '0;

    kd_tree_ctrl #(
      .PATCH_WIDTH  (PW),
      .ADDRESS_WIDTH(AW),
      .NUM_NODES    (NN),
      .TREE_LATENCY (TL),
      .PIPELINED    (P)
    ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .node_enq     (node_enq),
      .node_full_n  (w_nfn),
      .fsm_enable   (w_fe),
      .load_done    (w_ld),
      .patch_valid  (patch_valid),
      .patch_ready  (w_pr),
      .patch_data   (patch_data),
      .tree_patch   (w_tp),
      .tree_leaf_idx(leaf),
      .result_valid (w_rv),
      .result_index (w_idx),
      .busy         (w_busy),
      .proto_err    (w_perr)
    );

    // Tree stand-in: leaf = low bits of the patch, two edges after it changes.
    always @(posedge clk) begin
      h1   <= w_tp[AW-1:0];
      leaf <= h1;
    end

    // Model: phase 0 idle, 1 load, 2 search; k = edges seen since reset;
    // each in-flight patch remembers the edge that accepted it.
    item_t         q[$];
    int            m_phase = 0;
    int            m_cnt = 0;
    int            k = 0;
    bit            m_reload = 0, m_perr = 0, m_ld = 0, m_rv = 0, m_empty, m_acc;
    logic [AW-1:0] m_idx = '0;
    logic [PW-1:0] m_tp = '0;

    function automatic bit m_ready();
      if (m_phase != 2 || m_reload) return 1'b0;
      if (P == 1) return 1'b1;
      foreach (q[i]) if (k - q[i].a < TL) return 1'b0;
      return 1'b1;
    endfunction

    initial begin
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          q.delete();
          m_phase = 0; m_cnt = 0; k = 0;
          m_reload = 0; m_perr = 0; m_ld = 0; m_rv = 0;
          m_idx = '0; m_tp = '0;
        end else begin
          m_empty = (q.size() == 0);
          m_acc   = patch_valid && m_ready();
          m_ld    = 0;
          m_rv    = 0;
          if (q.size() > 0 && q[0].a + TL + 1 == k + 1) begin
            m_rv  = 1;
            m_idx = q[0].p[AW-1:0];
            void'(q.pop_front());
          end
          case (m_phase)
            0: begin
              if (node_enq) m_perr = 1;
              if (start) begin m_phase = 1; m_cnt = 0; end
            end
            1: begin
              if (start) m_cnt = 0;
              else if (node_enq) begin
                if (m_cnt == NN - 1) begin m_cnt = 0; m_ld = 1; m_phase = 2; end
                else m_cnt++;
              end
            end
            default: begin
              if (node_enq) m_perr = 1;
              if (m_reload && m_empty) begin m_phase = 1; m_cnt = 0; m_reload = 0; end
              else if (start) m_reload = 1;
            end
          endcase
          if (m_acc) begin
            q.push_back('{patch_data, k + 1});
            m_tp = patch_data;
          end
          k++;
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("i%0d fsm_enable", g),   w_fe,   m_phase == 1);
      chk($sformatf("i%0d node_full_n", g),  w_nfn,  m_phase == 1);
      chk($sformatf("i%0d busy", g),         w_busy, m_phase != 0);
      chk($sformatf("i%0d load_done", g),    w_ld,   m_ld);
      chk($sformatf("i%0d proto_err", g),    w_perr, m_perr);
      chk($sformatf("i%0d patch_ready", g),  w_pr,   m_ready());
      chk($sformatf("i%0d result_valid", g), w_rv,   m_rv);
      chk($sformatf("i%0d result_index", g), w_idx,  m_idx);
      chk($sformatf("i%0d tree_patch", g),   w_tp,   m_tp);
    end
  end

  always @(negedge clk) if (g_inst[0].w_ld) ld_count++;

  task automatic load_beats(input bit with_start, input int n, input bit gaps);
    if (with_start) begin start = 1'b1; tick(); start = 1'b0; end
    for (int b = 0; b < n; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      node_enq = 1'b1;
      tick();
      node_enq = 1'b0;
    end
  endtask

  initial begin
    int ld_base;
    int rv_seen;
    logic [63:0] r;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset busy", g_inst[0].w_busy, 1'b0);
    chk("reset patch_ready", g_inst[0].w_pr, 1'b0);
    chk("reset proto_err", g_inst[0].w_perr, 1'b0);

    // Full load with random gaps
    ld_base = ld_count;
    load_beats(1'b1, NN, 1'b1);
    chk("load_done after last beat", g_inst[0].w_ld, 1'b1);
    chk("fsm_enable off in search", g_inst[0].w_fe, 1'b0);
    tick();
    chk("single load_done", ld_count - ld_base, 1);

    // Three back-to-back patches
    patch_valid = 1'b1; patch_data = pat(63); tick();
    patch_data = pat(5); tick();
    patch_data = pat(4); tick();
    patch_valid = 1'b0; tick();
    chk("p1 first rv", g_inst[0].w_rv, 1'b1);
    chk("p1 first idx", g_inst[0].w_idx, 63);
    chk("p0 first idx", g_inst[1].w_idx, 63);
    tick();
    chk("p1 second idx", g_inst[0].w_idx, 5);
    chk("p0 no second rv", g_inst[1].w_rv, 1'b0);
    tick();
    chk("p1 third rv", g_inst[0].w_rv, 1'b1);
    chk("p1 third idx", g_inst[0].w_idx, 4);
    tick();
    chk("p1 rv ends", g_inst[0].w_rv, 1'b0);

    // One-outstanding spacing
    patch_valid = 1'b1; patch_data = pat(9);
    chk("p0 ready before accept", g_inst[1].w_pr, 1'b1);
    tick();
    patch_data = pat(10);
    chk("p0 ready low 1", g_inst[1].w_pr, 1'b0);
    tick();
    chk("p0 ready low 2", g_inst[1].w_pr, 1'b0);
    tick();
    chk("p0 ready back", g_inst[1].w_pr, 1'b1);
    tick();
    patch_valid = 1'b0;
    chk("p0 result 1 idx", g_inst[1].w_idx, 9);
    tick();
    tick();
    chk("p0 gap rv", g_inst[1].w_rv, 1'b0);
    tick();
    chk("p0 result 2 rv", g_inst[1].w_rv, 1'b1);
    chk("p0 result 2 idx", g_inst[1].w_idx, 10);
    repeat (4) tick();

    // Reload requested with two patches in flight
    patch_valid = 1'b1; patch_data = pat(20); tick();
    patch_data = pat(21); tick();
    patch_valid = 1'b0; start = 1'b1; tick();
    start = 1'b0;
    chk("reload drops ready", g_inst[0].w_pr, 1'b0);
    rv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (g_inst[0].w_rv) rv_seen++;
      if (g_inst[0].w_nfn) break;
    end
    chk("in-flight results drained", rv_seen, 2);
    chk("reload enters load", g_inst[0].w_nfn, 1'b1);
    ld_base = ld_count;
    load_beats(1'b0, NN, 1'b0);
    chk("reload load_done", g_inst[0].w_ld, 1'b1);
    tick();
    chk("reload single load_done", ld_count - ld_base, 1);

    // Stray node beat in search
    node_enq = 1'b1; tick(); node_enq = 1'b0;
    chk("search proto_err", g_inst[0].w_perr, 1'b1);
    chk("search stays busy", g_inst[0].w_busy, 1'b1);

    // Asynchronous reset mid-load
    load_beats(1'b1, 30, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", g_inst[0].w_busy, 1'b0);
    chk("async rst fsm_enable", g_inst[0].w_fe, 1'b0);
    chk("async rst proto_err", g_inst[0].w_perr, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    node_enq = 1'b1; tick(); node_enq = 1'b0;
    chk("idle proto_err", g_inst[0].w_perr, 1'b1);
    chk("idle stays idle", g_inst[0].w_busy, 1'b0);
    ld_base = ld_count;
    load_beats(1'b1, NN, 1'b1);
    tick();
    chk("post-reset single load_done", ld_count - ld_base, 1);

    // Randomized traffic, occasional reloads
    for (int i = 0; i < 2500; i++) begin
      r           = {$urandom(), $urandom()};
      start       = ($urandom_range(0, 299) == 0);
      node_enq    = ($urandom_range(0, 1) == 1);
      patch_valid = ($urandom_range(0, 2) != 0);
      patch_data  = r[PW-1:0];
      tick();
    end
    start = 1'b0; node_enq = 1'b0; patch_valid = 1'b0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
